// File: rtl/g2_cal.sv
`default_nettype none
// ============================================================================
// Module   : g2_cal
// Purpose  : Streaming g2 histogrammer. Start (a1) timestamps are kept in a
//            small circular buffer; each stop (a2) timestamp is correlated
//            against every retained start. Delays a2-a1 below NBINS increment
//            a histogram bin. After ACQ_CYCLES the histogram is streamed out
//            over a valid/ready port.
// Options  : G2CAL_SATURATE_EN - when defined, bin counts saturate instead of
//            wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module g2_cal #(
  parameter int DW         = 32,
  parameter int BIN_AW     = 10,
  parameter int A1_DEPTH   = 8,
  parameter int ACQ_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          RST,
  input  logic [DW-1:0] a1,
  input  logic          a1V,
  output logic          a1R,
  input  logic [DW-1:0] a2,
  input  logic          a2V,
  output logic          a2R,
  output logic [DW-1:0] g2Dat,
  output logic          g2V,
  input  logic          g2R
);

  localparam int NBINS = 1 << BIN_AW;
  localparam int PW    = (A1_DEPTH > 1) ? $clog2(A1_DEPTH) : 1;
  localparam int CW    = $clog2(A1_DEPTH + 1);
  localparam int TW    = $clog2(ACQ_CYCLES + 1);

  typedef enum logic [2:0] {CLEAR, ACQ, SCAN, DUMP, DONE} state_t;

  state_t            state_q, state_d;
  logic [BIN_AW-1:0] clr_q, clr_d;
  logic [DW-1:0]     a1_buf_q [A1_DEPTH];
  logic [DW-1:0]     a1_buf_d [A1_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     scan_idx_q, scan_idx_d;
  logic              scan_ph_q, scan_ph_d;
  logic [DW-1:0]     a2_q, a2_d;
  logic              hit_q, hit_d;
  logic [BIN_AW-1:0] addr_q, addr_d;
  logic [TW-1:0]     acq_q, acq_d;
  logic [BIN_AW:0]   rptr_q, rptr_d;
  logic [DW-1:0]     g2_dat_q, g2_dat_d;
  logic              g2_v_q, g2_v_d;

  logic [DW-1:0]     bin_mem [NBINS];
  logic [DW-1:0]     rd_q;
  logic              mem_we;
  logic [BIN_AW-1:0] mem_wa, mem_ra;
  logic [DW-1:0]     mem_wd;

  logic              acq_done, rdy, a1_fire, a2_fire;
  logic [DW-1:0]     delta, inc;

  assign acq_done = (acq_q == TW'(ACQ_CYCLES));
  assign rdy      = (state_q == ACQ) && !acq_done;
  assign a1_fire  = a1V && rdy;
  assign a2_fire  = a2V && rdy;
  assign delta    = a2_q - a1_buf_q[scan_idx_q];

`ifdef G2CAL_SATURATE_EN
  assign inc = (&rd_q) ? rd_q : rd_q + DW'(1);
`else
  assign inc = rd_q + DW'(1);
`endif

  // next-state, buffer, scan and dump control
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    a1_buf_d   = a1_buf_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    scan_idx_d = scan_idx_q;
    scan_ph_d  = scan_ph_q;
    a2_d       = a2_q;
    hit_d      = hit_q;
    addr_d     = addr_q;
    rptr_d     = rptr_q;
    g2_dat_d   = g2_dat_q;
    g2_v_d     = g2_v_q;
    mem_we     = 1'b0;
    mem_wa     = addr_q;
    mem_wd     = inc;
    acq_d      = ((state_q == ACQ || state_q == SCAN) && !acq_done) ? acq_q + TW'(1) : acq_q;

    case (state_q)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_wa   = clr_q;
        mem_wd   = '0;
        clr_d    = clr_q + BIN_AW'(1);
        wr_ptr_d = '0;
        cnt_d    = '0;
        acq_d    = '0;
        rptr_d   = '0;
        g2_v_d   = 1'b0;
        if (&clr_q) state_d = ACQ;
      end
      ACQ: begin
        if (acq_done) begin
          state_d = DUMP;
        end else begin
          // a1 lands before the a2 scan starts so a same-cycle pair correlates
          if (a1_fire) begin
            a1_buf_d[wr_ptr_q] = a1;
            wr_ptr_d = (wr_ptr_q == PW'(A1_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (cnt_q != CW'(A1_DEPTH)) cnt_d = cnt_q + CW'(1);
          end
          if (a2_fire) begin
            a2_d       = a2;
            scan_idx_d = '0;
            scan_ph_d  = 1'b0;
            if (cnt_d != '0) state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (!scan_ph_q) begin
          // phase 0: compute delay, issue bin read
          hit_d     = (delta[DW-1:BIN_AW] == '0);
          addr_d    = delta[BIN_AW-1:0];
          scan_ph_d = 1'b1;
        end else begin
          // phase 1: write back incremented count (skipped on a miss)
          mem_we    = hit_q;
          scan_ph_d = 1'b0;
          if (CW'(scan_idx_q) + CW'(1) == cnt_q) state_d = ACQ;
          else scan_idx_d = scan_idx_q + PW'(1);
        end
      end
      DUMP: begin
        // rd_q always holds bin[rptr_q] because the read address tracks rptr_d
        if (!g2_v_q || g2R) begin
          if (!rptr_q[BIN_AW]) begin
            g2_dat_d = rd_q;
            g2_v_d   = 1'b1;
            rptr_d   = rptr_q + (BIN_AW+1)'(1);
          end else begin
            g2_v_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        g2_v_d = 1'b0;
      end
      default: state_d = CLEAR;
    endcase

    mem_ra = (state_q == SCAN && !scan_ph_q) ? delta[BIN_AW-1:0] : rptr_d[BIN_AW-1:0];
  end

  // control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q    <= CLEAR;
      clr_q      <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      scan_idx_q <= '0;
      scan_ph_q  <= 1'b0;
      acq_q      <= '0;
      rptr_q     <= '0;
      g2_dat_q   <= '0;
      g2_v_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      scan_idx_q <= scan_idx_d;
      scan_ph_q  <= scan_ph_d;
      acq_q      <= acq_d;
      rptr_q     <= rptr_d;
      g2_dat_q   <= g2_dat_d;
      g2_v_q     <= g2_v_d;
    end
  end

  // datapath registers; always written before being consumed
  always_ff @(posedge clk) begin
    a1_buf_q <= a1_buf_d;
    a2_q     <= a2_d;
    hit_q    <= hit_d;
    addr_q   <= addr_d;
  end

  // histogram RAM: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (mem_we && RST) bin_mem[mem_wa] <= mem_wd;
    rd_q <= bin_mem[mem_ra];
  end

  assign a1R   = rdy;
  assign a2R   = rdy;
  assign g2Dat = g2_dat_q;
  assign g2V   = g2_v_q;

endmodule
`default_nettype wire

// File: tb/tb_g2_cal.sv
`default_nettype none
// ============================================================================
// Module   : tb_g2_cal
// Purpose  : Self-checking bench for g2_cal: directed cases plus a randomized
//            acquisition compared against a behavioural histogram model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_g2_cal;

  localparam int DW    = 32;
  localparam int NB    = 1024;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] a1 = '0, a2 = '0;
  logic          a1V = 1'b0, a2V = 1'b0, g2R = 1'b0;
  logic          a1R, a2R, g2V;
  logic [DW-1:0] g2Dat;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] hist  [NB];
  logic [DW-1:0] dumpv [NB];
  logic [DW-1:0] a1q   [$];

  g2_cal #(.DW(DW), .BIN_AW(10), .A1_DEPTH(DEPTH), .ACQ_CYCLES(4096)) dut (
    .clk(clk), .RST(RST),
    .a1(a1), .a1V(a1V), .a1R(a1R),
    .a2(a2), .a2V(a2V), .a2R(a2R),
    .g2Dat(g2Dat), .g2V(g2V), .g2R(g2R)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] bump(input logic [DW-1:0] v);
`ifdef G2CAL_SATURATE_EN
    return (v == {DW{1'b1}}) ? v : v + 1;
`else
    return v + 1;
`endif
  endfunction

  // reference: every retained start correlates with each stop
  task automatic model_a1(input logic [DW-1:0] v);
    a1q.push_back(v);
    if (a1q.size() > DEPTH) void'(a1q.pop_front());
  endtask

  task automatic model_a2(input logic [DW-1:0] v);
    logic [DW-1:0] d;
    foreach (a1q[i]) begin
      d = v - a1q[i];
      if (d < NB) hist[d] = bump(hist[d]);
    end
  endtask

  function automatic int nonzero();
    int n = 0;
    for (int i = 0; i < NB; i++) if (dumpv[i] != 0) n++;
    return n;
  endfunction

  task automatic start_run(input bit chk_rst);
    int lowcnt;
    RST = 1'b0; a1V = 1'b0; a2V = 1'b0; g2R = 1'b0;
    repeat (3) @(negedge clk);
    if (chk_rst) begin
      chk("rst_a1R", a1R, 0);
      chk("rst_a2R", a2R, 0);
      chk("rst_g2V", g2V, 0);
      chk("rst_g2Dat", g2Dat, 0);
    end
    for (int i = 0; i < NB; i++) begin hist[i] = '0; dumpv[i] = '0; end
    a1q.delete();
    RST = 1'b1;
    lowcnt = 0;
    for (int i = 1; i < NB; i++) begin
      @(negedge clk);
      if (!a1R && !a2R && !g2V) lowcnt++;
    end
    @(negedge clk);
    chk("clear_low_cycles", lowcnt, NB - 1);
    chk("rdy_after_clear", {a1R, a2R}, 2'b11);
  endtask

  task automatic xfer(input bit do1, input logic [DW-1:0] v1, input bit do2, input logic [DW-1:0] v2);
    int n = 0;
    a1V = do1; a1 = v1; a2V = do2; a2 = v2;
    while (!((!do1 || a1R) && (!do2 || a2R)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("rdy_timeout", 0, 1);
      a1V = 1'b0; a2V = 1'b0;
      return;
    end
    @(negedge clk);
    a1V = 1'b0; a2V = 1'b0;
    if (do1) model_a1(v1);
    if (do2) model_a2(v2);
  endtask

  task automatic dump_phase(input bit stall, input bit bp);
    int beats = 0, n = 0, stalls = 0, vcnt = 0;
    while (beats < NB && n < 12000) begin
      if (stall && beats == 3 && stalls < 5) begin
        g2R = 1'b0;
        stalls++;
        chk("stall_valid", g2V, 1);
        chk("stall_hold", g2Dat, hist[3]);
      end else begin
        g2R = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (g2V && g2R) begin
          dumpv[beats] = g2Dat;
          chk("beat", g2Dat, hist[beats]);
          beats++;
        end
      end
      @(negedge clk);
      n++;
    end
    chk("beat_count", beats, NB);
    g2R = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (g2V) vcnt++;
    end
    chk("done_g2V_low", vcnt, 0);
    chk("done_rdy_low", {a1R, a2R}, 2'b00);
  endtask

  initial begin
    logic [DW-1:0] base;
    // a1=100, a2=105 -> bin5
    start_run(1'b1);
    xfer(1, 100, 0, 0);
    xfer(0, 0, 1, 105);
    dump_phase(0, 0);
    chk("c1_bin5", dumpv[5], 1);
    chk("c1_nonzero", nonzero(), 1);

    // a1 > a2 wraps to a huge delay
    start_run(1'b0);
    xfer(1, 200, 0, 0);
    xfer(0, 0, 1, 199);
    dump_phase(0, 0);
    chk("c2_nonzero", nonzero(), 0);

    // delay exactly NB is out of range
    start_run(1'b0);
    xfer(1, 0, 0, 0);
    xfer(0, 0, 1, 1024);
    dump_phase(0, 0);
    chk("c3_nonzero", nonzero(), 0);

    // delay NB-1 is the last bin
    start_run(1'b0);
    xfer(1, 0, 0, 0);
    xfer(0, 0, 1, 1023);
    dump_phase(0, 0);
    chk("c4_bin1023", dumpv[1023], 1);
    chk("c4_nonzero", nonzero(), 1);

    // nine starts overflow the buffer: oldest (0) is gone
    start_run(1'b0);
    for (int v = 0; v < 9; v++) xfer(1, v, 0, 0);
    xfer(0, 0, 1, 10);
    dump_phase(0, 0);
    for (int b = 2; b <= 9; b++) chk("c5_bin_hit", dumpv[b], 1);
    chk("c5_bin10", dumpv[10], 0);
    chk("c5_nonzero", nonzero(), 8);

    // same-cycle a1/a2, plus output stall at beat 3
    start_run(1'b0);
    xfer(1, 50, 1, 50);
    dump_phase(1, 0);
    chk("c6_bin0", dumpv[0], 1);

    // randomized traffic with wrap-around base and output backpressure
    start_run(1'b0);
    base = $urandom;
    for (int e = 0; e < 120; e++) begin
      case ($urandom_range(0, 2))
        0: xfer(1, base + $urandom_range(0, 1200), 0, 0);
        1: xfer(0, 0, 1, base + $urandom_range(0, 1200));
        default: xfer(1, base + $urandom_range(0, 40), 1, base + $urandom_range(0, 80));
      endcase
    end
    dump_phase(0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
